seg7_scan_ctrl: RTL

Sequencer for the 4-digit multiplexed 7-segment display. It owns digit selection, per-digit on-time, inter-digit blanking against ghosting, hex-to-segment decode and tear-free update of displayed data. Upstream logic posts a 16-bit value with a load strobe. The block drives the anode and cathode pins directly.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_slot_timer.sv | 82 ++++++++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
// Segment encoding is active-low {g,f,e,d,c,b,a}; anodes are active-low.
package seg7_pkg;

    // Slot phases: anodes dark during S_BLANK, selected digit lit during S_ON.
    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Hex-to-segment table, entry 15 leftmost down to entry 0 rightmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit slot sequencer: counts ce-qualified cycles per slot, splits each slot
// into a blanking phase and an on phase, advances the digit index and flags
// the frame boundary (digit 3 -> digit 0).
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int BLANK    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce,
    output slot_state_t o_state,
    output logic [1:0]  o_q,
    output logic        o_wrap,
    output logic        o_frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_q;
    logic [1:0]       w_q_nxt;
    logic             w_wrap;
    logic             r_frame_tick;

    // State, slot counter, digit index and frame pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_BLANK;
            r_cnt        <= '0;
            r_q          <= 2'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_q          <= w_q_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    // Next-state logic; nothing moves on cycles with ce low.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_wrap      = 1'b0;
        if (i_ce) begin
            case (r_state)
                S_BLANK: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BLANK - 1)) begin
                        w_state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (r_cnt == CNT_W'(PRESCALE - 1)) begin
                        w_cnt_nxt   = '0;
                        w_q_nxt     = r_q + 2'd1;
                        w_state_nxt = S_BLANK;
                        w_wrap      = (r_q == 2'd3);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_q          = r_q;
    assign o_wrap       = w_wrap;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment display controller.
// Loads are staged and only enter the displayed (shadow) registers at the
// frame boundary, so a frame never mixes old and new data.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int BLANK    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] dat,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  q,
    output logic        frame_tick
);

    slot_state_t w_state;
    logic [1:0]  w_q;
    logic        w_wrap;
    logic        w_frame_tick;

    logic [15:0] r_stg_dat;
    logic [3:0]  r_stg_dp;
    logic [3:0]  r_stg_en;
    logic        r_pending;
    logic [15:0] r_sh_dat;
    logic [3:0]  r_sh_dp;
    logic [3:0]  r_sh_en;
    logic        r_load_ack;

    logic [3:0]  w_lz;
    logic [3:0]  w_show;
    logic [3:0]  w_nib;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    seg7_slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_ce         (ce),
        .o_state      (w_state),
        .o_q          (w_q),
        .o_wrap       (w_wrap),
        .o_frame_tick (w_frame_tick)
    );

    // Staging/shadow handshake: loads stage until the frame boundary; a load
    // that coincides with the boundary goes straight to the shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_dat  <= 16'h0000;
            r_stg_dp   <= 4'h0;
            r_stg_en   <= 4'hF;
            r_pending  <= 1'b0;
            r_sh_dat   <= 16'h0000;
            r_sh_dp    <= 4'h0;
            r_sh_en    <= 4'hF;
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (w_wrap && load) begin
                r_stg_dat  <= dat;
                r_stg_dp   <= dp_in;
                r_stg_en   <= dig_en;
                r_sh_dat   <= dat;
                r_sh_dp    <= dp_in;
                r_sh_en    <= dig_en;
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_sh_dat   <= r_stg_dat;
                r_sh_dp    <= r_stg_dp;
                r_sh_en    <= r_stg_en;
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (load) begin
                r_stg_dat <= dat;
                r_stg_dp  <= dp_in;
                r_stg_en  <= dig_en;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // Leading-zero suppression chain from the top digit down; a lit dp or a
    // non-zero nibble stops it, and digit 0 is always eligible.
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (r_sh_dat[15:12] == 4'h0) && !r_sh_dp[3];
        w_lz[2] = w_lz[3] && (r_sh_dat[11:8] == 4'h0) && !r_sh_dp[2];
        w_lz[1] = w_lz[2] && (r_sh_dat[7:4] == 4'h0) && !r_sh_dp[1];
    end
`else
    assign w_lz = 4'b0000;
`endif

    assign w_show = r_sh_en & ~w_lz;
    assign w_nib  = r_sh_dat[{w_q, 2'b00} +: 4];

    // Registered pin drivers, one cycle behind the slot state and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if ((w_state == S_ON) && w_show[w_q]) begin
            r_an  <= ~(4'b0001 << w_q);
            r_seg <= seg_decode(w_nib);
            r_dp  <= ~r_sh_dp[w_q];
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign q          = w_q;
    assign frame_tick = w_frame_tick;
    assign load_ack   = r_load_ack;

endmodule
